// File: rtl/rv_pkg.sv
// Shared RISC-V core package: default widths, the architectural register
// address / data typedefs used by decode and writeback, and a helper that
// decides whether a register index refers to real, writable storage.
package rv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [XLEN_DEF-1:0] xlen_t;
    typedef logic [AW_DEF-1:0]   reg_addr_t;

    // True when addr names a storage location that holds state: inside the
    // array and not the hardwired zero register.
    function automatic logic reg_valid(input int unsigned addr,
                                       input int unsigned nregs,
                                       input bit          zero_reg);
        return (addr < nregs) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard for the register file.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr0_ok/wr0_addr       write port 0 actually updating a register
//   wr1_ok/wr1_addr       write port 1 actually updating a register
//   iss_en/iss_addr       mark a destination register pending
//   rd_addr               packed read addresses (NRD x AW)
//   rd_busy               per read port: addressed register has a write outstanding
//   pend_any              OR of all pending bits
module rf_scoreboard
    import rv_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr0_ok,
    input  logic [AW-1:0]     wr0_addr,
    input  logic              wr1_ok,
    input  logic [AW-1:0]     wr1_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    output logic              pend_any
);

    logic [NREGS-1:0] pend_reg;
    logic [NREGS-1:0] pend_next;
    logic             iss_ok;

    // Issues to the zero register or past the end of the array never mark anything.
    assign iss_ok = iss_en && reg_valid(32'(iss_addr), NREGS, ZERO_REG != 0);

    // Set beats clear so a reissue in the writeback cycle stays pending.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
            logic set_hit;
            logic clr_hit;
            assign set_hit = iss_ok && (iss_addr == AW'(gi));
            assign clr_hit = (wr0_ok && (wr0_addr == AW'(gi))) ||
                             (wr1_ok && (wr1_addr == AW'(gi)));
            assign pend_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : pend_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    assign pend_any = |pend_reg;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_busy
            logic [AW-1:0] ra;
            logic          in_range;
            logic          wb_hit;
            assign ra       = rd_addr[gi*AW +: AW];
            assign in_range = ({1'b0, ra} < (AW+1)'(NREGS));
            // A writeback landing this cycle already satisfies the reader.
            assign wb_hit   = (BYPASS != 0) &&
                              ((wr0_ok && (wr0_addr == ra)) || (wr1_ok && (wr1_addr == ra)));
            assign rd_busy[gi] = in_range && pend_reg[ra] && !wb_hit;
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two
// prioritised synchronous write ports (port 1 wins), optional same-cycle
// write forwarding and a RAW-hazard pending scoreboard.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   rd_addr / rd_data / rd_busy   packed read ports, k uses slice k
//   wr0_en/addr/data              write port 0 (low priority)
//   wr1_en/addr/data              write port 1 (high priority)
//   iss_en / iss_addr             mark destination register pending
//   pend_any                      any register pending
module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                pend_any
);

    logic [XLEN-1:0] mem_reg [NREGS];
    logic            wr0_ok;
    logic            wr1_ok;

    assign wr0_ok = wr0_en && reg_valid(32'(wr0_addr), NREGS, ZERO_REG != 0);
    assign wr1_ok = wr1_en && reg_valid(32'(wr1_addr), NREGS, ZERO_REG != 0);

    // Port 1 is written last so it takes the register on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (wr0_ok) begin
                mem_reg[wr0_addr] <= wr0_data;
            end
            if (wr1_ok) begin
                mem_reg[wr1_addr] <= wr1_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic            rd_ok;
            logic [XLEN-1:0] data;
            assign ra    = rd_addr[gi*AW +: AW];
            assign rd_ok = reg_valid(32'(ra), NREGS, ZERO_REG != 0);

            always_comb begin
                data = '0;
                if (rd_ok) begin
                    data = mem_reg[ra];
                    if (BYPASS != 0) begin
                        if (wr0_en && (wr0_addr == ra)) data = wr0_data;
                        if (wr1_en && (wr1_addr == ra)) data = wr1_data;
                    end
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = data;
        end
    endgenerate

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .AW       (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_ok   (wr0_ok),
        .wr0_addr (wr0_addr),
        .wr1_ok   (wr1_ok),
        .wr1_addr (wr1_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .pend_any (pend_any)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Two register files share one stimulus stream:
//   A: NREGS=32, ZERO_REG=1, BYPASS=1
//   B: NREGS=24, ZERO_REG=0, BYPASS=0
// Each is compared every cycle against an array-based reference model.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic                wr0_en, wr1_en, iss_en;
    logic [AW-1:0]       wr0_addr, wr1_addr, iss_addr;
    logic [XLEN-1:0]     wr0_data, wr1_data;
    logic [NRD*XLEN-1:0] rd_data_a, rd_data_b;
    logic [NRD-1:0]      rd_busy_a, rd_busy_b;
    logic                pend_any_a, pend_any_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .pend_any(pend_any_a)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(24), .NRD(NRD), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .pend_any(pend_any_b)
    );

    // ---------------- reference model ----------------
    int unsigned cfg_nregs [2] = '{32, 24};
    bit          cfg_byp   [2] = '{1'b1, 1'b0};
    bit          cfg_zero  [2] = '{1'b1, 1'b0};
    logic [31:0] m_mem  [2][32];
    bit          m_pend [2][32];

    function automatic bit m_ok(int i, int a);
        return (a < int'(cfg_nregs[i])) && !(cfg_zero[i] && a == 0);
    endfunction

    function automatic logic [31:0] m_data(int i, int a);
        if (!m_ok(i, a)) return 32'h0;
        if (cfg_byp[i]) begin
            if (wr1_en && int'(wr1_addr) == a) return wr1_data;
            if (wr0_en && int'(wr0_addr) == a) return wr0_data;
        end
        return m_mem[i][a];
    endfunction

    function automatic bit m_busy(int i, int a);
        bit writing;
        if (a >= int'(cfg_nregs[i])) return 1'b0;
        writing = (wr0_en && int'(wr0_addr) == a && m_ok(i, a)) ||
                  (wr1_en && int'(wr1_addr) == a && m_ok(i, a));
        if (cfg_byp[i] && writing) return 1'b0;
        return m_pend[i][a];
    endfunction

    function automatic bit m_any(int i);
        bit r = 1'b0;
        for (int a = 0; a < 32; a++) r |= m_pend[i][a];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 32; a++) begin
                m_mem[i][a]  = 32'h0;
                m_pend[i][a] = 1'b0;
            end
    endtask

    task automatic m_edge();
        for (int i = 0; i < 2; i++) begin
            if (wr0_en && m_ok(i, int'(wr0_addr))) begin
                m_mem[i][wr0_addr]  = wr0_data;
                m_pend[i][wr0_addr] = 1'b0;
            end
            if (wr1_en && m_ok(i, int'(wr1_addr))) begin
                m_mem[i][wr1_addr]  = wr1_data;
                m_pend[i][wr1_addr] = 1'b0;
            end
            if (iss_en && m_ok(i, int'(iss_addr))) m_pend[i][iss_addr] = 1'b1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int k = 0; k < NRD; k++) begin
            int a;
            a = int'(rd_addr[k*AW +: AW]);
            chk($sformatf("%s A p%0d data x%0d", tag, k, a), rd_data_a[k*XLEN +: XLEN], m_data(0, a));
            chk($sformatf("%s A p%0d busy x%0d", tag, k, a), {31'b0, rd_busy_a[k]}, {31'b0, m_busy(0, a)});
            chk($sformatf("%s B p%0d data x%0d", tag, k, a), rd_data_b[k*XLEN +: XLEN], m_data(1, a));
            chk($sformatf("%s B p%0d busy x%0d", tag, k, a), {31'b0, rd_busy_b[k]}, {31'b0, m_busy(1, a)});
        end
        chk($sformatf("%s A pend_any", tag), {31'b0, pend_any_a}, {31'b0, m_any(0)});
        chk($sformatf("%s B pend_any", tag), {31'b0, pend_any_b}, {31'b0, m_any(1)});
    endtask

    // One clock cycle: drive after the falling edge, check, then advance the model.
    task automatic step(string tag, bit w0e, int w0a, logic [31:0] w0d,
                        bit w1e, int w1a, logic [31:0] w1d,
                        bit ie, int ia, int r0, int r1);
        @(negedge clk);
        wr0_en = w0e; wr0_addr = AW'(w0a); wr0_data = w0d;
        wr1_en = w1e; wr1_addr = AW'(w1a); wr1_data = w1d;
        iss_en = ie;  iss_addr = AW'(ia);
        rd_addr = {AW'(r1), AW'(r0)};
        #1;
        check_all(tag);
        $display("step %-10s w0=%0b x%0d=%h w1=%0b x%0d=%h iss=%0b x%0d rd=x%0d,x%0d",
                 tag, w0e, w0a, w0d, w1e, w1a, w1d, ie, ia, r0, r1);
        @(posedge clk);
        if (rst_n) m_edge();
        else       m_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
        m_reset();

        // Reset state, then release away from the clock edge.
        step("reset", 1, 5, 32'h1, 0, 0, 0, 1, 5, 5, 0);
        #2 rst_n = 1'b1;

        // Asynchronous reset clears storage and pending immediately.
        step("rst_wr", 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 6, 5, 6);
        step("rst_rd", 0, 0, 0, 0, 0, 0, 0, 0, 5, 6);
        @(negedge clk);
        wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
        rd_addr = {AW'(6), AW'(5)};
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all("rst_async");
        $display("step rst_async rst_n pulsed low mid-cycle rd=x5,x6");
        #2 rst_n = 1'b1;
        step("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 5, 6);

        // Zero register.
        step("zero_wr", 0, 0, 0, 1, 0, 32'h1234, 1, 0, 0, 0);
        step("zero_rd1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("zero_rd2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Write collision: port 1 wins.
        step("coll_wr", 1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0, 7, 7);
        step("coll_rd", 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);

        // Bypass versus array path.
        step("byp_old", 1, 3, 32'h0BADF00D, 0, 0, 0, 0, 0, 3, 4);
        step("byp_new", 1, 3, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 3, 4);
        step("byp_next", 0, 0, 0, 0, 0, 0, 0, 0, 3, 4);

        // Scoreboard: issue, hold, writeback, reissue with writeback.
        step("sb_iss", 0, 0, 0, 0, 0, 0, 1, 9, 9, 8);
        step("sb_c1", 0, 0, 0, 0, 0, 0, 0, 0, 9, 8);
        step("sb_c2", 0, 0, 0, 0, 0, 0, 0, 0, 9, 8);
        step("sb_c3", 0, 0, 0, 0, 0, 0, 0, 0, 9, 8);
        step("sb_wb", 0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 8);
        step("sb_c5", 0, 0, 0, 0, 0, 0, 0, 0, 9, 8);
        step("sb_reiss", 1, 9, 32'h77, 0, 0, 0, 1, 9, 9, 8);
        step("sb_held", 0, 0, 0, 0, 0, 0, 0, 0, 9, 8);
        step("sb_clr", 1, 9, 32'h78, 0, 0, 0, 0, 0, 9, 8);

        // Out-of-range address (only B has 24 registers).
        step("oor_wr", 1, 30, 32'hCAFEF00D, 0, 0, 0, 1, 30, 30, 23);
        step("oor_rd", 0, 0, 0, 0, 0, 0, 0, 0, 30, 23);

        // Randomised traffic, biased towards a small address pool for collisions.
        for (int n = 0; n < 400; n++) begin
            int a[6];
            for (int j = 0; j < 6; j++)
                a[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                   : int'($urandom_range(0, 9));
            step("rand", 1'($urandom_range(0, 1)), a[0], $urandom,
                         1'($urandom_range(0, 1)), a[1], $urandom,
                         1'($urandom_range(0, 1)), a[2], a[3], a[4]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
